// File: rtl/yuv_encoder_pkg.sv
// rtl/yuv_encoder_pkg.sv - state encoding, matrix coefficients, rounding helpers and default addresses for yuv_encoder
package yuv_encoder_pkg;

    typedef logic [1:0] enc_state_t;
    localparam enc_state_t ST_IDLE  = 2'd0;
    localparam enc_state_t ST_LOOP  = 2'd1;
    localparam enc_state_t ST_DRAIN = 2'd2;

    // RGB-to-YUV matrix, scaled by 2^16
    localparam int signed CY_R = 16843;
    localparam int signed CY_G = 33030;
    localparam int signed CY_B = 6423;
    localparam int signed CU_R = -9699;
    localparam int signed CU_G = -19071;
    localparam int signed CU_B = 28770;
    localparam int signed CV_R = 28770;
    localparam int signed CV_G = -24117;
    localparam int signed CV_B = -4653;

    localparam int signed Y_OFFSET  = 16 * 65536;
    localparam int signed UV_OFFSET = 128 * 65536;
    localparam int signed RND_HALF  = 32768;
    localparam int signed RND_AVG   = 65536;

    localparam int DEF_IMG_PIXELS = 76800;
    localparam int DEF_Y_BASE     = 0;
    localparam int DEF_U_BASE     = 38400;
    localparam int DEF_V_BASE     = 57600;
    localparam int DEF_RGB_BASE   = 146944;

    function automatic logic [7:0] clip_u8(input logic signed [31:0] v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 255) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

    // Single-pixel rounding: clip((acc + 2^15) >>> 16)
    function automatic logic [7:0] round_clip(input logic signed [31:0] acc);
        logic signed [31:0] t;
        t = (acc + RND_HALF) >>> 16;
        return clip_u8(t);
    endfunction

    // Pair average: clip((a + b + 2^16) >>> 17)
    function automatic logic [7:0] avg_round_clip(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
        logic signed [31:0] t;
        t = (a + b + RND_AVG) >>> 17;
        return clip_u8(t);
    endfunction

endpackage

// File: rtl/yuv_encoder_csc_pixel.sv
// rtl/yuv_encoder_csc_pixel.sv - registered RGB-to-YUV matrix, accumulators valid 2 cycles after rgb_i
module csc_pixel
    import yuv_encoder_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [23:0]        rgb_i,
    input  logic               uv_en_i,
    output logic signed [31:0] y_acc_o,
    output logic signed [31:0] u_acc_o,
    output logic signed [31:0] v_acc_o
);

    logic [23:0]        rgb_q;
    logic               uv_en_q;
    logic signed [31:0] r_s, g_s, b_s;
    logic signed [31:0] y_d, u_d, v_d;
    logic signed [31:0] y_q, u_q, v_q;

    assign r_s = $signed({24'd0, rgb_q[23:16]});
    assign g_s = $signed({24'd0, rgb_q[15:8]});
    assign b_s = $signed({24'd0, rgb_q[7:0]});

    assign y_d = CY_R * r_s + CY_G * g_s + CY_B * b_s + Y_OFFSET;
    assign u_d = CU_R * r_s + CU_G * g_s + CU_B * b_s + UV_OFFSET;
    assign v_d = CV_R * r_s + CV_G * g_s + CV_B * b_s + UV_OFFSET;

    // Stage 1: capture the pixel and whether its chroma is wanted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q   <= '0;
            uv_en_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_i;
            uv_en_q <= uv_en_i;
        end
    end

    // Stage 2: register the products; chroma holds when not wanted so its multipliers stay idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q <= '0;
            u_q <= '0;
            v_q <= '0;
        end else begin
            y_q <= y_d;
            if (uv_en_q) begin
                u_q <= u_d;
                v_q <= v_d;
            end
        end
    end

    assign y_acc_o = y_q;
    assign u_acc_o = u_q;
    assign v_acc_o = v_q;

endmodule

// File: rtl/yuv_encoder.sv
// rtl/yuv_encoder.sv - SRAM RGB to planar subsampled YUV encoder; YUV_ENC_UV_AVG_EN selects pair-averaged chroma
module yuv_encoder
    import yuv_encoder_pkg::*;
#(
    parameter int IMG_PIXELS = DEF_IMG_PIXELS,
    parameter int Y_BASE     = DEF_Y_BASE,
    parameter int U_BASE     = DEF_U_BASE,
    parameter int V_BASE     = DEF_V_BASE,
    parameter int RGB_BASE   = DEF_RGB_BASE
)(
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    input  logic        enc_start,
    output logic        enc_done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    localparam int          GROUPS   = IMG_PIXELS / 4;
    localparam logic [16:0] LAST_GRP = 17'(GROUPS - 1);

    enc_state_t  state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [16:0] grp_q, grp_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;

    logic [17:0] grp_rgb, wg, wr_addr;
    logic [15:0] wr_word;

    logic [15:0]        hold_q;
    logic               pix_head, csc_uv_en;
    logic [23:0]        csc_rgb;
    logic signed [31:0] y_acc, u_acc, v_acc;
    logic signed [31:0] st_ue_q, st_ve_q;
    logic [7:0]         st_y0_q, st_y1_q, st_y2_q, st_u0_q, st_v0_q;
    logic [7:0]         y_byte, u_pair, v_pair;
    logic [15:0]        wr_y0_q, wr_y1_q, wr_u_q, wr_v_q;

    // Group k reads RGB words 6k..6k+5; writes in iteration k belong to group k-1
    assign grp_rgb = 18'(RGB_BASE) + 18'(grp_q) * 18'd6;
    assign wg      = 18'(grp_q) - 18'd1;

    // Address and data of the write slot that follows the current slot (slots 6..9)
    always_comb begin
        wr_addr = 18'(V_BASE) + wg;
        wr_word = wr_v_q;
        case (slot_q)
            4'd5: begin wr_addr = 18'(Y_BASE) + (wg << 1);         wr_word = wr_y0_q; end
            4'd6: begin wr_addr = 18'(Y_BASE) + (wg << 1) + 18'd1; wr_word = wr_y1_q; end
            4'd7: begin wr_addr = 18'(U_BASE) + wg;                wr_word = wr_u_q;  end
            default: ;
        endcase
    end

    // Sequencer: 10-slot iterations, 6 reads then 4 writes; outputs are computed one slot ahead
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        grp_d   = grp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_start) begin
                    state_d = ST_LOOP;
                    slot_d  = 4'd0;
                    grp_d   = '0;
                    addr_d  = 18'(RGB_BASE);
                    done_d  = 1'b0;
                end
            end
            ST_LOOP, ST_DRAIN: begin
                if (slot_q == 4'd9) begin
                    slot_d = 4'd0;
                    if (state_q == ST_DRAIN) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        grp_d = grp_q + 17'd1;
                        if (grp_q == LAST_GRP) begin
                            state_d = ST_DRAIN;
                        end else begin
                            addr_d = grp_rgb + 18'd6;
                        end
                    end
                end else begin
                    slot_d = slot_q + 4'd1;
                    if (slot_q < 4'd5) begin
                        if (state_q == ST_LOOP) begin
                            addr_d = grp_rgb + 18'(slot_q) + 18'd1;
                        end
                    end else if (grp_q != 17'd0) begin
                        addr_d  = wr_addr;
                        wdata_d = wr_word;
                        we_n_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and SRAM port registers
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            slot_q  <= 4'd0;
            grp_q   <= '0;
            addr_q  <= 18'(RGB_BASE);
            wdata_q <= 16'd0;
            we_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            grp_q   <= grp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            done_q  <= done_d;
        end
    end

    // Read data lands 3 slots after its address: words 0..5 arrive in slots 3..8.
    // Pixels 0 and 2 complete in slots 4 and 7 from the held word plus the new high byte;
    // pixels 1 and 3 complete in slots 5 and 8 from the held low byte plus the new word.
    assign pix_head = (slot_q == 4'd4) || (slot_q == 4'd7);
    assign csc_rgb  = pix_head ? {hold_q, SRAM_read_data[15:8]}
                               : {hold_q[7:0], SRAM_read_data};

`ifdef YUV_ENC_UV_AVG_EN
    assign csc_uv_en = 1'b1;
    assign u_pair    = avg_round_clip(st_ue_q, u_acc);
    assign v_pair    = avg_round_clip(st_ve_q, v_acc);
`else
    assign csc_uv_en = pix_head;
    assign u_pair    = round_clip(st_ue_q);
    assign v_pair    = round_clip(st_ve_q);
`endif

    assign y_byte = round_clip(y_acc);

    csc_pixel u_csc (
        .clk_i   (CLOCK_50_I),
        .rst_i   (Reset),
        .rgb_i   (csc_rgb),
        .uv_en_i (csc_uv_en),
        .y_acc_o (y_acc),
        .u_acc_o (u_acc),
        .v_acc_o (v_acc)
    );

    // Collect pixel results (slots 6, 7, 9 and next slot 0) and pack the four output words in slot 0
    always_ff @(posedge CLOCK_50_I) begin
        hold_q <= SRAM_read_data;
        case (slot_q)
            4'd6: begin st_y0_q <= y_byte; st_ue_q <= u_acc;  st_ve_q <= v_acc;  end
            4'd7: begin st_y1_q <= y_byte; st_u0_q <= u_pair; st_v0_q <= v_pair; end
            4'd9: begin st_y2_q <= y_byte; st_ue_q <= u_acc;  st_ve_q <= v_acc;  end
            4'd0: begin
                wr_y0_q <= {st_y0_q, st_y1_q};
                wr_y1_q <= {st_y2_q, y_byte};
                wr_u_q  <= {st_u0_q, u_pair};
                wr_v_q  <= {st_v0_q, v_pair};
            end
            default: ;
        endcase
    end

    assign enc_done        = done_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_yuv_encoder.sv
// tb/tb_yuv_encoder.sv - directed bench for yuv_encoder on a 16-pixel image with a 3-cycle SRAM model
module tb_yuv_encoder;

    localparam int IMG = 16;
    localparam int G   = IMG / 4;
    localparam int YB  = 0;
    localparam int UB  = 16;
    localparam int VB  = 24;
    localparam int RB  = 64;

`ifdef YUV_ENC_UV_AVG_EN
    localparam logic [7:0] U_RB = 8'h6D;
    localparam logic [7:0] V_RB = 8'hB8;
`else
    localparam logic [7:0] U_RB = 8'h5A;
    localparam logic [7:0] V_RB = 8'hF0;
`endif

    // groups: {red,red | red,black}, all black, all white, {black,white | white,black}
    localparam logic [15:0] RGB_TBL [24] = '{
        16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
        16'h0000, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFF00, 16'h0000};
    localparam logic [15:0] Y_EXP [8] = '{16'h5252, 16'h5210, 16'h1010, 16'h1010,
                                          16'hEBEB, 16'hEBEB, 16'h10EB, 16'hEB10};
    localparam logic [15:0] U_EXP [4] = '{{8'h5A, U_RB}, 16'h8080, 16'h8080, 16'h8080};
    localparam logic [15:0] V_EXP [4] = '{{8'hF0, V_RB}, 16'h8080, 16'h8080, 16'h8080};

    logic        clk = 1'b0;
    logic        rst, enc_start, enc_done, we_n;
    logic [17:0] addr;
    logic [15:0] wdata, rdata;
    logic [15:0] mem [0:127];
    logic [6:0]  a1, a2, a3;
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [15:0] ld_data;
    int          n_checks, n_fail;

    always #5 clk = ~clk;

    yuv_encoder #(
        .IMG_PIXELS (IMG),
        .Y_BASE     (YB),
        .U_BASE     (UB),
        .V_BASE     (VB),
        .RGB_BASE   (RB)
    ) dut (
        .CLOCK_50_I      (clk),
        .Reset           (rst),
        .enc_start       (enc_start),
        .enc_done        (enc_done),
        .SRAM_address    (addr),
        .SRAM_write_data (wdata),
        .SRAM_we_n       (we_n),
        .SRAM_read_data  (rdata)
    );

    always @(posedge clk) begin
        a1 <= addr[6:0];
        a2 <= a1;
        a3 <= a2;
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (!we_n) mem[addr[6:0]] <= wdata;
    end
    assign rdata = mem[a3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 7'(i);
            ld_data = (i >= RB && i < RB + 24) ? RGB_TBL[i - RB] : 16'hDEAD;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"},  32'(addr),     32'(RB));
        check_eq({tag, "_wdata"}, 32'(wdata),    32'd0);
        check_eq({tag, "_we_n"},  32'(we_n),     32'd1);
        check_eq({tag, "_done"},  32'(enc_done), 32'd0);
    endtask

    task automatic run_frame(input string tag);
        logic        exp_we, chk_a;
        logic [17:0] exp_a;
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        enc_start = 1'b0;
        for (int c = 1; c <= 10 * G + 10; c++) begin
            int i, s;
            i = (c - 1) / 10;
            s = (c - 1) % 10;
            exp_we = 1'b1;
            chk_a  = 1'b1;
            exp_a  = '0;
            if (s < 6) begin
                exp_a = (i < G) ? 18'(RB + 6 * i + s) : 18'(VB + G - 2);
            end else if (i == 0) begin
                chk_a = 1'b0;
            end else begin
                exp_we = 1'b0;
                case (s)
                    6: exp_a = 18'(YB + 2 * (i - 1));
                    7: exp_a = 18'(YB + 2 * (i - 1) + 1);
                    8: exp_a = 18'(UB + i - 1);
                    default: exp_a = 18'(VB + i - 1);
                endcase
            end
            check_eq($sformatf("%s_we_n_c%0d", tag, c), 32'(we_n), 32'(exp_we));
            if (chk_a) check_eq($sformatf("%s_addr_c%0d", tag, c), 32'(addr), 32'(exp_a));
            if (c == 1 || c == 10 * G + 10)
                check_eq($sformatf("%s_done_c%0d", tag, c), 32'(enc_done), 32'd0);
            enc_start = (c == 15);
            @(negedge clk);
        end
        check_eq({tag, "_done_rise"}, 32'(enc_done), 32'd1);
        check_eq({tag, "_we_n_end"},  32'(we_n),     32'd1);
    endtask

    task automatic check_planes(input string tag);
        for (int w = 0; w < 2 * G; w++)
            check_eq($sformatf("%s_y%0d", tag, w), 32'(mem[YB + w]), 32'(Y_EXP[w]));
        for (int g = 0; g < G; g++) begin
            check_eq($sformatf("%s_u%0d", tag, g), 32'(mem[UB + g]), 32'(U_EXP[g]));
            check_eq($sformatf("%s_v%0d", tag, g), 32'(mem[VB + g]), 32'(V_EXP[g]));
        end
        check_eq({tag, "_y_past_end"}, 32'(mem[YB + 2 * G]), 32'h0000DEAD);
        check_eq({tag, "_v_past_end"}, 32'(mem[VB + G]),     32'h0000DEAD);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        enc_start = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        load_mem();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        run_frame("run1");
        repeat (5) @(negedge clk);
        check_eq("done_hold", 32'(enc_done), 32'd1);
        check_planes("run1");

        // restart, then reset during a write slot (cycle 18 = iteration 1, L7)
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        enc_start = 1'b0;
        check_eq("done_clear", 32'(enc_done), 32'd0);
        repeat (17) @(negedge clk);
        check_eq("pre_rst_we_n", 32'(we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst_mid");

        load_mem();
        run_frame("run2");
        check_planes("run2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
